// File: rtl/tabla_verdad_captura.sv
// tabla_verdad_captura: sweeps every N-bit input vector into a combinational block,
// captures its single output into a 2^N-bit truth table and compares it to a golden table.
module tabla_verdad_captura #(
    parameter int N = 4,
    parameter int SETTLE = 1,
    parameter logic [2**N-1:0] EXPECTED = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            x,
    output logic [N-1:0]    vec,
    output logic [2**N-1:0] tabla,
    output logic            busy,
    output logic            done,
    output logic            ok
);
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            vec   <= '0;
            tabla <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    state <= ST_WAIT;
                    vec   <= '0;
                    cnt   <= '0;
                    tabla <= '0;
                    ok    <= 1'b0;
                    busy  <= 1'b1;
                end
                // terminal check precedes the increment so vec never wraps mid-sweep
                ST_WAIT: if (cnt == CW'(SETTLE - 1)) begin
                    tabla[vec] <= x;
                    cnt        <= '0;
                    if (vec == '1) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        vec <= vec + 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
                ST_DONE: begin
                    ok    <= tabla == EXPECTED;
                    vec   <= '0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tabla_verdad_captura.sv
// tb_tabla_verdad_captura: random and directed truth tables swept by a SETTLE=1 and a SETTLE=3 instance.
module tb_tabla_verdad_captura;
    logic clk = 0, rst, st1, st3, x1, x3;
    logic [3:0] vec1, vec3;
    logic [15:0] tabla1, tabla3;
    logic busy1, busy3, done1, done3, ok1, ok3;
    logic [15:0] tt [2];
    int total = 0, bad = 0;

    always #5 clk = ~clk;
    assign x1 = tt[0][vec1];
    assign x3 = tt[1][vec3];

    tabla_verdad_captura #(.N(4), .SETTLE(1), .EXPECTED(16'hF000)) u1 (
        .clk(clk), .rst(rst), .start(st1), .x(x1), .vec(vec1), .tabla(tabla1),
        .busy(busy1), .done(done1), .ok(ok1));
    tabla_verdad_captura #(.N(4), .SETTLE(3), .EXPECTED(16'h6996)) u3 (
        .clk(clk), .rst(rst), .start(st3), .x(x3), .vec(vec3), .tabla(tabla3),
        .busy(busy3), .done(done3), .ok(ok3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_table(input int f);
        logic [15:0] t;
        logic [3:0] v;
        for (int k = 0; k < 16; k++) begin
            v = 4'(k);
            t[k] = f == 0 ? v[3] & v[2] : f == 1 ? 1'b0 : ^v;
        end
        return t;
    endfunction

    function automatic logic [15:0] tabla_of(input int w); return w != 0 ? tabla3 : tabla1; endfunction
    function automatic logic [3:0] vec_of(input int w); return w != 0 ? vec3 : vec1; endfunction
    function automatic logic busy_of(input int w); return w != 0 ? busy3 : busy1; endfunction
    function automatic logic done_of(input int w); return w != 0 ? done3 : done1; endfunction
    function automatic logic ok_of(input int w); return w != 0 ? ok3 : ok1; endfunction

    task automatic set_start(input int w, input logic v);
        if (w != 0) st3 = v;
        else st1 = v;
    endtask

    task automatic chk_zero(input int w);
        chk("rst_vec", vec_of(w), 0);
        chk("rst_tabla", tabla_of(w), 0);
        chk("rst_busy", busy_of(w), 0);
        chk("rst_done", done_of(w), 0);
        chk("rst_ok", ok_of(w), 0);
    endtask

    // mode 0: single start pulse, 1: start held high on exit, 2: start poked during busy and done
    task automatic sweep(input int w, input logic [15:0] t, input int mode);
        int s;
        logic [15:0] exp_t;
        s = w != 0 ? 3 : 1;
        exp_t = w != 0 ? 16'h6996 : 16'hF000;
        tt[w] = t;
        set_start(w, 1'b1);
        @(posedge clk);
        for (int j = 0; j < 16 * s; j++) begin
            @(negedge clk);
            chk("sweep_busy", busy_of(w), 1);
            chk("sweep_done", done_of(w), 0);
            chk("sweep_ok", ok_of(w), 0);
            chk("sweep_vec", vec_of(w), j / s);
            chk("sweep_tabla", tabla_of(w), t & 16'((32'd1 << (j / s)) - 1));
            if (mode != 1 && j == 0) set_start(w, 1'b0);
            if (mode == 2 && j == 4) set_start(w, 1'b1);
            if (mode == 2 && j == 5) set_start(w, 1'b0);
        end
        @(negedge clk);
        chk("end_done", done_of(w), 1);
        chk("end_busy", busy_of(w), 0);
        chk("end_tabla", tabla_of(w), t);
        chk("end_ok_early", ok_of(w), 0);
        if (mode == 2) set_start(w, 1'b1);
        @(negedge clk);
        chk("idle_done", done_of(w), 0);
        chk("idle_busy", busy_of(w), 0);
        chk("idle_vec", vec_of(w), 0);
        chk("idle_tabla", tabla_of(w), t);
        chk("idle_ok", ok_of(w), 32'(t == exp_t));
        if (mode != 1) set_start(w, 1'b0);
    endtask

    initial begin
        rst = 1;
        st1 = 0;
        st3 = 0;
        tt[0] = '0;
        tt[1] = '0;
        repeat (2) @(negedge clk);
        chk_zero(0);
        chk_zero(1);
        rst = 0;
        sweep(0, model_table(0), 0);
        sweep(0, model_table(1), 0);
        sweep(1, model_table(2), 0);
        sweep(1, 16'($urandom), 0);
        // asynchronous reset while u1 is driving vector 5
        tt[0] = 16'($urandom);
        st1 = 1;
        @(posedge clk);
        @(negedge clk);
        st1 = 0;
        repeat (5) @(negedge clk);
        chk("pre_rst_vec", vec1, 5);
        #2 rst = 1;
        #1;
        chk_zero(0);
        chk_zero(1);
        @(negedge clk);
        rst = 0;
        sweep(0, 16'($urandom), 0);
        sweep(0, model_table(0), 1);
        sweep(0, 16'($urandom), 0);
        sweep(0, model_table(0), 2);
        sweep(1, model_table(2), 2);
        for (int i = 0; i < 4; i++) begin
            sweep(0, 16'($urandom), 32'($urandom_range(0, 2)) == 2 ? 2 : 0);
            sweep(1, 16'($urandom), 0);
        end
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
